// File: rtl/rand_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rand_arbiter
// Description : Round-robin arbiter handing out values from a shared 4-bit
//               XNOR LFSR, advanced STEPS times per delivery.
// Revision    : 1.0 - initial release
// ============================================================================
module rand_arbiter #(
    parameter int N_REQ = 4,
    parameter int STEPS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             stir,
    input  logic             seed_load,
    input  logic [3:0]       seed,
    output logic [N_REQ-1:0] gnt,
    output logic [3:0]       rnd_out,
    output logic             rnd_valid,
    output logic             busy
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [3:0]       c_last_step = 4'(STEPS - 1);
    localparam logic [N_REQ-1:0] c_one       = N_REQ'(1);
    localparam logic [IW-1:0]    c_last_init = IW'(N_REQ - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_STEP    = 2'd1,
        S_DELIVER = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [3:0]    r_lfsr;
    logic [3:0]    r_cnt;
    logic [IW-1:0] r_last;
    logic [IW-1:0] r_winner;
    logic [3:0]    w_lfsr_next;
    logic [IW-1:0] w_idx;
    logic [IW-1:0] w_pick;
    logic          w_found;
    logic          w_adv;
    logic          w_start;
    logic          w_deliver;

    assign w_lfsr_next = {r_lfsr[2:0], ~(r_lfsr[3] ^ r_lfsr[2])};

    // Search starts one past the last winner so every requester gets a turn.
    always_comb begin
        w_idx   = '0;
        w_pick  = '0;
        w_found = 1'b0;
        for (int i = 1; i <= N_REQ; i++) begin
            w_idx = IW'((int'(r_last) + i) % N_REQ);
            if (!w_found && req[w_idx]) begin
                w_found = 1'b1;
                w_pick  = w_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_adv        = 1'b0;
        w_start      = 1'b0;
        w_deliver    = 1'b0;
        if (seed_load) begin
            w_state_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_adv = stir;
                    if (w_found) begin
                        w_state_next = S_STEP;
                        w_start      = 1'b1;
                    end
                end
                S_STEP: begin
                    w_adv = 1'b1;
                    if (r_cnt == c_last_step) begin
                        w_state_next = S_DELIVER;
                        w_deliver    = 1'b1;
                    end
                end
                S_DELIVER: w_state_next = S_IDLE;
                default:   w_state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_lfsr    <= 4'b0000;
            r_cnt     <= 4'd0;
            r_last    <= c_last_init;
            r_winner  <= '0;
            gnt       <= '0;
            rnd_out   <= 4'b0000;
            rnd_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            gnt       <= '0;
            rnd_valid <= 1'b0;
            busy      <= (w_state_next != S_IDLE);

            // All-ones would lock the XNOR LFSR, so it is mapped to zero.
            if (seed_load) begin
                r_lfsr <= (seed == 4'b1111) ? 4'b0000 : seed;
            end else if (w_adv) begin
                r_lfsr <= w_lfsr_next;
            end

            if (w_start) begin
                r_winner <= w_pick;
                r_cnt    <= 4'd0;
            end else if (r_state == S_STEP && !seed_load) begin
                r_cnt <= r_cnt + 4'd1;
            end

            // Outputs carry the value produced by the final step edge.
            if (w_deliver) begin
                gnt       <= c_one << r_winner;
                rnd_valid <= 1'b1;
                rnd_out   <= w_lfsr_next;
                r_last    <= r_winner;
            end
        end
    end

endmodule
`default_nettype wire
